// File: rtl/ram128_arbiter.sv
// ram128_arbiter: two-port round-robin arbiter with bounded lock bursts in front of a single-port RAM128.
// Read data is returned one cycle after the grant, straight from the RAM output.
module ram128_arbiter #(
  parameter int AW       = 7,
  parameter int MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_lock,
  input  logic [3:0]    p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_rsp,
  output logic [31:0]   p0_rdata,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_lock,
  input  logic [3:0]    p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_rsp,
  output logic [31:0]   p1_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] ML = CW'(MAX_LOCK);
  logic          last, last_lock;
  logic [CW-1:0] cnt;
  logic          fl_act, fl_port, fl_rd;
  logic          v0, v1, hold, sel, gnt, lk;
  always_comb begin
    v0   = p0_valid & RESETn;
    v1   = p1_valid & RESETn;
    hold = last_lock && (cnt < ML) && (last ? v1 : v0);
    sel  = (v0 && v1) ? (hold ? last : !last) : v1;
    gnt  = v0 | v1;
    lk   = sel ? p1_lock : p0_lock;
  end
  assign ram_en    = gnt;
  assign ram_we    = gnt ? (sel ? p1_we : p0_we) : '0;
  assign ram_addr  = gnt ? (sel ? p1_addr : p0_addr) : '0;
  assign ram_wdata = gnt ? (sel ? p1_wdata : p0_wdata) : '0;
  assign p0_ready  = gnt & !sel;
  assign p1_ready  = gnt & sel;
  // lock_cnt only grows while the same locked port keeps winning; it saturates at the bound
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      last      <= 1'b1;
      last_lock <= 1'b0;
      cnt       <= '0;
      fl_act    <= 1'b0;
      fl_port   <= 1'b0;
      fl_rd     <= 1'b0;
    end else begin
      fl_act  <= gnt;
      fl_port <= sel;
      fl_rd   <= ram_we == 4'h0;
      if (gnt) begin
        last      <= sel;
        last_lock <= lk;
        cnt       <= (sel == last && last_lock && lk) ? ((cnt == ML) ? cnt : cnt + 1'b1) : '0;
      end
    end
  end
  assign p0_rsp   = fl_act & !fl_port;
  assign p1_rsp   = fl_act & fl_port;
  assign p0_rdata = (p0_rsp && fl_rd) ? ram_rdata : '0;
  assign p1_rdata = (p1_rsp && fl_rd) ? ram_rdata : '0;
endmodule

// File: tb/tb_ram128_arbiter.sv
// tb_ram128_arbiter: directed bench with a behavioural RAM128 and a scoreboard monitor for grants and responses.
module tb_ram128_arbiter;
  logic        CLK = 0, RESETn = 0;
  logic        v[2], lk[2], rdy[2], rsp[2];
  logic [3:0]  we[2];
  logic [6:0]  ad[2];
  logic [31:0] wd[2], rd[2];
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [6:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata = 0;
  logic [31:0] mem [128];
  logic [31:0] rq0[$], rq1[$];
  logic        gq[$];
  logic        pend[2] = '{0, 0};
  int          n_chk = 0, n_fail = 0;

  ram128_arbiter dut (
    .CLK(CLK), .RESETn(RESETn),
    .p0_valid(v[0]), .p0_ready(rdy[0]), .p0_lock(lk[0]), .p0_we(we[0]), .p0_addr(ad[0]),
    .p0_wdata(wd[0]), .p0_rsp(rsp[0]), .p0_rdata(rd[0]),
    .p1_valid(v[1]), .p1_ready(rdy[1]), .p1_lock(lk[1]), .p1_we(we[1]), .p1_addr(ad[1]),
    .p1_wdata(wd[1]), .p1_rsp(rsp[1]), .p1_rdata(rd[1]),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  // RAM128 model: byte-enabled write, registered read of the old word, 0 when not enabled
  always @(posedge CLK) begin
    if (ram_en)
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= ram_en ? mem[ram_addr] : 32'h0;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input int p, input logic [3:0] w, input logic [6:0] a,
                       input logic [31:0] d, input logic l, input logic [31:0] exp);
    int n = 0;
    if (p == 0) rq0.push_back(exp); else rq1.push_back(exp);
    v[p] = 1; we[p] = w; ad[p] = a; wd[p] = d; lk[p] = l;
    do begin
      @(negedge CLK);
      n++;
    end while (!rdy[p] && n < 50);
    if (!rdy[p]) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout port %0d: got no ready expected ready within 50 cycles", p);
    end
    @(posedge CLK); #1;
    v[p] = 0; lk[p] = 0;
  endtask

  // monitor: responses must follow ready by exactly one cycle and carry the queued data
  always @(negedge CLK) begin
    if (!RESETn) begin
      pend[0] = 0; pend[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [31:0] e;
        check($sformatf("rsp%0d_timing", i), 32'(rsp[i]), 32'(pend[i]));
        if (rsp[i]) begin
          if ((i == 0 ? rq0.size() : rq1.size()) == 0)
            check($sformatf("rsp%0d_unexpected", i), 32'(rsp[i]), 32'h0);
          else begin
            e = (i == 0) ? rq0.pop_front() : rq1.pop_front();
            check($sformatf("rdata%0d", i), rd[i], e);
          end
        end else check($sformatf("rdata%0d_idle", i), rd[i], 32'h0);
      end
      check("ready_excl", 32'(rdy[0] & rdy[1]), 32'h0);
      check("ram_en", 32'(ram_en), 32'(rdy[0] | rdy[1]));
      if (ram_en && gq.size() > 0) check("grant_port", 32'(rdy[1]), 32'(gq.pop_front()));
      pend[0] = rdy[0]; pend[1] = rdy[1];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; lk[i] = 0; we[i] = 0; ad[i] = 0; wd[i] = 0;
    end
    #12;
    check("rst_en", 32'(ram_en), 0);
    check("rst_rdy", 32'({rdy[0], rdy[1], rsp[0], rsp[1]}), 0);
    @(posedge CLK); #1 RESETn = 1;
    // single write then read on port 0
    issue(0, 4'hF, 7'h05, 32'hDEADBEEF, 0, 32'h0);
    issue(0, 4'h0, 7'h05, 32'h0, 0, 32'hDEADBEEF);
    // byte enables at the top address
    issue(0, 4'hF, 7'h7F, 32'h11223344, 0, 32'h0);
    issue(0, 4'b0101, 7'h7F, 32'hAABBCCDD, 0, 32'h0);
    issue(0, 4'h0, 7'h7F, 32'h0, 0, 32'h11BB33DD);
    // port 1 write: RAM shows the old word but the response data must be 0
    issue(1, 4'hF, 7'h7F, 32'hCAFEF00D, 0, 32'h0);
    @(negedge CLK);
    check("idle_en", 32'(ram_en), 0);
    @(negedge CLK);
    check("idle_rsp", 32'({rsp[0], rsp[1]}), 0);
    @(posedge CLK); #1;
    // contention without lock alternates starting with port 0
    for (int k = 0; k < 3; k++) begin gq.push_back(0); gq.push_back(1); end
    fork
      begin for (int k = 0; k < 3; k++) issue(0, 4'h0, 7'h05, 32'h0, 0, 32'hDEADBEEF); end
      begin for (int k = 0; k < 3; k++) issue(1, 4'hF, 7'(16 + k), 32'h1000 + k, 0, 32'h0); end
    join
    check("contention_done", gq.size(), 0);
    // asynchronous reset with an access in flight
    v[0] = 1; v[1] = 1; we[0] = 4'hF; we[1] = 4'hF; ad[0] = 7'h30; ad[1] = 7'h31;
    wd[0] = 32'h55; wd[1] = 32'h66;
    @(posedge CLK); #1;
    RESETn = 0;
    #1;
    check("arst_en_we", 32'({ram_en, ram_we}), 0);
    check("arst_addr", 32'(ram_addr), 0);
    check("arst_wdata", ram_wdata, 0);
    check("arst_rdy_rsp", 32'({rdy[0], rdy[1], rsp[0], rsp[1]}), 0);
    check("arst_rdata", rd[0] | rd[1], 0);
    v[0] = 0; v[1] = 0;
    @(posedge CLK); #1 RESETn = 1;
    gq.push_back(0); gq.push_back(1);
    fork
      issue(0, 4'hF, 7'h40, 32'h1, 0, 32'h0);
      issue(1, 4'hF, 7'h41, 32'h2, 0, 32'h0);
    join
    // locked burst: port 0 takes 1+4 grants, then port 1 gets one
    gq = '{0, 0, 0, 0, 0, 1, 0, 1};
    fork
      begin for (int k = 0; k < 6; k++) issue(0, 4'hF, 7'(32 + k), 32'h2000 + k, 1, 32'h0); end
      begin for (int k = 0; k < 2; k++) issue(1, 4'h0, 7'h05, 32'h0, 0, 32'hDEADBEEF); end
    join
    repeat (3) @(negedge CLK);
    check("lock_done", gq.size(), 0);
    check("rq0_empty", rq0.size(), 0);
    check("rq1_empty", rq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
